// File: rtl/emin_stream.sv
// emin_stream -- streams Emin(j,i), j = 0..i, for one T row i per job.
//
// Flow: start_in latches i and reads T(i) from the T BRAM. The block then issues
// j = 0..i, one per cycle, while output credits remain. Each issue reads T(j-1)
// (j = 0 uses an all-zero row) into a fixed-latency multiply/divide pipeline.
// Results land in a show-ahead output FIFO drained with valid/ready. A credit is
// taken at issue and returned at pop, so the pipeline never has to stall and the
// FIFO can never overflow.
//
// Optional feature: define EMIN_SAT_EN to make every add/sub and every >>>FRAC_BITS
// truncation saturate, and to clamp alpha/beta to [-2.0, +2.0). Without it all
// arithmetic wraps and no clamp logic is built.
//
// Ports
//   clk_in          clock
//   rst_in          asynchronous reset, active high
//   start_in, i_in  job request; taken only while idle; i_in >= I pulses err_out
//   busy_out        high from the accepted start until the last result is popped
//   err_out         one-cycle pulse for a rejected request
//   t_req_out       T BRAM read address
//   t_req_valid_out T BRAM read strobe
//   t_resp_in       {T2,T1,T0}, valid RD_LATENCY cycles after the strobe
//   j_out, data_out, div0_out  head result: j, Emin(j,i), zero-denominator flag
//   out_valid_out   FIFO non-empty
//   out_ready_in    pop the head when out_valid_out is also high
module emin_stream #(
  parameter int BIT_WIDTH      = 32,
  parameter int FRAC_BITS      = 16,
  parameter int I              = 160,
  parameter int RD_LATENCY     = 2,
  parameter int DIV_LATENCY    = 64,
  parameter int OUT_FIFO_DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [$clog2(I)-1:0]   i_in,
  output logic                   busy_out,
  output logic                   err_out,
  output logic [$clog2(I)-1:0]   t_req_out,
  output logic                   t_req_valid_out,
  input  logic [3*BIT_WIDTH-1:0] t_resp_in,
  output logic [$clog2(I)-1:0]   j_out,
  output logic [BIT_WIDTH-1:0]   data_out,
  output logic                   div0_out,
  output logic                   out_valid_out,
  input  logic                   out_ready_in
);
  localparam int BW  = BIT_WIDTH;
  localparam int F   = FRAC_BITS;
  localparam int AW  = $clog2(I);
  localparam int W2  = 2 * BW + 2;
  localparam int PW  = $clog2(OUT_FIFO_DEPTH);
  localparam int CW  = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int FCW = $clog2(RD_LATENCY + 1);
  localparam int EW  = AW + 1 + BW;

  localparam logic [AW:0]   I_LIM     = (AW + 1)'(I);
  localparam logic [CW-1:0] CRED_FULL = CW'(OUT_FIFO_DEPTH);

  typedef logic signed [BW-1:0] word_t;
  typedef logic signed [W2-1:0] wide_t;

`ifdef EMIN_SAT_EN
  localparam wide_t SMAX = wide_t'({1'b0, {(BW-1){1'b1}}});
  localparam wide_t SMIN = -SMAX - wide_t'(1);
  localparam wide_t ATWO = wide_t'(2) <<< F;
  localparam wide_t AMAX = ATWO - wide_t'(1);
  localparam wide_t AMIN = -ATWO;
`endif

  // Reduce a wide intermediate to a word: wrap, or saturate when enabled.
  function automatic word_t fit(input wide_t x);
`ifdef EMIN_SAT_EN
    if (x > SMAX) return word_t'(SMAX[BW-1:0]);
    if (x < SMIN) return word_t'(SMIN[BW-1:0]);
`endif
    return word_t'(x[BW-1:0]);
  endfunction

  // Q-format product: full-width multiply, then >>> F.
  function automatic word_t mulq(input word_t a, input word_t b);
    wide_t p;
    p = wide_t'(a) * wide_t'(b);
    return fit(p >>> F);
  endfunction

  // Q-format quotient, truncating toward zero; caller guarantees den != 0.
  function automatic word_t divq(input word_t num, input word_t den);
    wide_t q;
    q = (wide_t'(num) <<< F) / wide_t'(den);
`ifdef EMIN_SAT_EN
    if (q > AMAX) q = AMAX;
    else if (q < AMIN) q = AMIN;
`endif
    return fit(q);
  endfunction

  // ---------------------------------------------------------------- control
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   i_reg, i_next;
  logic [AW-1:0]   j_reg, j_next;
  logic [FCW-1:0]  fcnt_reg, fcnt_next;
  logic [CW-1:0]   credits_reg, credits_next;
  logic [3*BW-1:0] ti_reg, ti_next;
  logic            err_reg, err_next;
  logic [AW-1:0]   treq_addr_reg, treq_addr_next;
  logic            treq_vld_reg, treq_vld_next;
  logic            iss_vld_reg, iss_vld_next;
  logic [AW-1:0]   iss_j_reg, iss_j_next;
  logic            iss_zero_reg, iss_zero_next;
  logic            issue;
  logic            pop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= S_IDLE;
      i_reg         <= '0;
      j_reg         <= '0;
      fcnt_reg      <= '0;
      credits_reg   <= CRED_FULL;
      ti_reg        <= '0;
      err_reg       <= 1'b0;
      treq_addr_reg <= '0;
      treq_vld_reg  <= 1'b0;
      iss_vld_reg   <= 1'b0;
      iss_j_reg     <= '0;
      iss_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      i_reg         <= i_next;
      j_reg         <= j_next;
      fcnt_reg      <= fcnt_next;
      credits_reg   <= credits_next;
      ti_reg        <= ti_next;
      err_reg       <= err_next;
      treq_addr_reg <= treq_addr_next;
      treq_vld_reg  <= treq_vld_next;
      iss_vld_reg   <= iss_vld_next;
      iss_j_reg     <= iss_j_next;
      iss_zero_reg  <= iss_zero_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    i_next         = i_reg;
    j_next         = j_reg;
    fcnt_next      = fcnt_reg;
    ti_next        = ti_reg;
    err_next       = 1'b0;
    treq_addr_next = treq_addr_reg;
    treq_vld_next  = 1'b0;
    iss_vld_next   = 1'b0;
    iss_j_next     = iss_j_reg;
    iss_zero_next  = 1'b0;
    issue          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_in) begin
          if ({1'b0, i_in} < I_LIM) begin
            i_next         = i_in;
            treq_addr_next = i_in;
            treq_vld_next  = 1'b1;
            fcnt_next      = '0;
            state_next     = S_FETCH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // The strobe is high in the first FETCH cycle (count 0), so the row
        // is on t_resp_in exactly when the count reaches RD_LATENCY.
        if (fcnt_reg == FCW'(RD_LATENCY)) begin
          ti_next    = t_resp_in;
          j_next     = '0;
          state_next = S_ISSUE;
        end else begin
          fcnt_next = fcnt_reg + 1'b1;
        end
      end
      S_ISSUE: begin
        if (credits_reg != '0) begin
          issue         = 1'b1;
          iss_vld_next  = 1'b1;
          iss_j_next    = j_reg;
          iss_zero_next = (j_reg == '0);
          if (j_reg != '0) begin
            treq_vld_next  = 1'b1;
            treq_addr_next = j_reg - 1'b1;
          end
          if (j_reg == i_reg) state_next = S_DRAIN;
          else                j_next     = j_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        // All credits home means nothing is in flight and the FIFO is empty.
        if (credits_reg == CRED_FULL) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    credits_next = credits_reg - CW'(issue) + CW'(pop);
  end

  assign busy_out        = (state_reg != S_IDLE);
  assign err_out         = err_reg;
  assign t_req_out       = treq_addr_reg;
  assign t_req_valid_out = treq_vld_reg;

  // --------------------------------------------------------------- datapath
  logic [RD_LATENCY-1:0]  rd_vld_reg;
  logic [AW-1:0]          rd_j_reg    [RD_LATENCY];
  logic                   rd_zero_reg [RD_LATENCY];
  logic                   s1_vld_reg, s2_vld_reg, s3_vld_reg, e_vld_reg;
  logic [AW-1:0]          s1_j_reg, s2_j_reg, s3_j_reg, e_j_reg;
  word_t                  s1_r_reg [3];
  word_t                  s2_r_reg [3];
  word_t                  s3_r_reg [3];
  word_t                  s2_p00_reg, s2_p01_reg, s2_p02_reg, s2_p11_reg, s2_p12_reg;
  word_t                  s3_numa_reg, s3_numb_reg, s3_den_reg;
  logic [DIV_LATENCY-1:0] dv_vld_reg;
  logic [AW-1:0]          dv_j_reg     [DIV_LATENCY];
  logic                   dv_div0_reg  [DIV_LATENCY];
  word_t                  dv_alpha_reg [DIV_LATENCY];
  word_t                  dv_beta_reg  [DIV_LATENCY];
  word_t                  dv_r_reg     [DIV_LATENCY][3];
  logic                   e_div0_reg;
  word_t                  e_data_reg;

  // r_k = T_i[k] - T(j-1)[k], with T(-1) taken as zero for j = 0.
  word_t r_comb [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_r
    word_t t_prev;
    assign t_prev     = rd_zero_reg[RD_LATENCY-1] ? word_t'(0) : word_t'(t_resp_in[gi*BW +: BW]);
    assign r_comb[gi] = fit(wide_t'(word_t'(ti_reg[gi*BW +: BW])) - wide_t'(t_prev));
  end

  word_t alpha_comb, beta_comb;
  logic  div0_comb;
  always_comb begin
    div0_comb  = (s3_den_reg == '0);
    alpha_comb = '0;
    beta_comb  = '0;
    if (!div0_comb) begin
      alpha_comb = divq(s3_numa_reg, s3_den_reg);
      beta_comb  = divq(s3_numb_reg, s3_den_reg);
    end
  end

  // Emin = r0 - (r1*alpha>>>F) - (r2*beta>>>F), each subtraction reduced separately.
  word_t m1_comb, m2_comb, epart_comb, emin_comb;
  assign m1_comb    = mulq(dv_r_reg[DIV_LATENCY-1][1], dv_alpha_reg[DIV_LATENCY-1]);
  assign m2_comb    = mulq(dv_r_reg[DIV_LATENCY-1][2], dv_beta_reg[DIV_LATENCY-1]);
  assign epart_comb = fit(wide_t'(dv_r_reg[DIV_LATENCY-1][0]) - wide_t'(m1_comb));
  assign emin_comb  = fit(wide_t'(epart_comb) - wide_t'(m2_comb));

  // Valid bits carry the reset; the payload registers beside them do not need it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_vld_reg <= '0;
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
      s3_vld_reg <= 1'b0;
      dv_vld_reg <= '0;
      e_vld_reg  <= 1'b0;
    end else begin
      rd_vld_reg[0] <= iss_vld_reg;
      for (int k = 1; k < RD_LATENCY; k++) rd_vld_reg[k] <= rd_vld_reg[k-1];
      s1_vld_reg    <= rd_vld_reg[RD_LATENCY-1];
      s2_vld_reg    <= s1_vld_reg;
      s3_vld_reg    <= s2_vld_reg;
      dv_vld_reg[0] <= s3_vld_reg;
      for (int k = 1; k < DIV_LATENCY; k++) dv_vld_reg[k] <= dv_vld_reg[k-1];
      e_vld_reg     <= dv_vld_reg[DIV_LATENCY-1];
    end
  end

  always_ff @(posedge clk_in) begin
    rd_j_reg[0]    <= iss_j_reg;
    rd_zero_reg[0] <= iss_zero_reg;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_j_reg[k]    <= rd_j_reg[k-1];
      rd_zero_reg[k] <= rd_zero_reg[k-1];
    end
    s1_j_reg   <= rd_j_reg[RD_LATENCY-1];
    s1_r_reg   <= r_comb;
    s2_j_reg   <= s1_j_reg;
    s2_r_reg   <= s1_r_reg;
    s2_p00_reg <= mulq(s1_r_reg[0], s1_r_reg[0]);
    s2_p01_reg <= mulq(s1_r_reg[0], s1_r_reg[1]);
    s2_p02_reg <= mulq(s1_r_reg[0], s1_r_reg[2]);
    s2_p11_reg <= mulq(s1_r_reg[1], s1_r_reg[1]);
    s2_p12_reg <= mulq(s1_r_reg[1], s1_r_reg[2]);
    s3_j_reg    <= s2_j_reg;
    s3_r_reg    <= s2_r_reg;
    s3_numa_reg <= fit(wide_t'(s2_p01_reg) - wide_t'(s2_p12_reg));
    s3_numb_reg <= fit(wide_t'(s2_p02_reg) - wide_t'(s2_p11_reg));
    s3_den_reg  <= fit(wide_t'(s2_p00_reg) - wide_t'(s2_p11_reg));
    // Divider modelled as a combinational quotient followed by a delay line.
    dv_j_reg[0]     <= s3_j_reg;
    dv_div0_reg[0]  <= div0_comb;
    dv_alpha_reg[0] <= alpha_comb;
    dv_beta_reg[0]  <= beta_comb;
    dv_r_reg[0]     <= s3_r_reg;
    for (int k = 1; k < DIV_LATENCY; k++) begin
      dv_j_reg[k]     <= dv_j_reg[k-1];
      dv_div0_reg[k]  <= dv_div0_reg[k-1];
      dv_alpha_reg[k] <= dv_alpha_reg[k-1];
      dv_beta_reg[k]  <= dv_beta_reg[k-1];
      dv_r_reg[k]     <= dv_r_reg[k-1];
    end
    e_j_reg    <= dv_j_reg[DIV_LATENCY-1];
    e_div0_reg <= dv_div0_reg[DIV_LATENCY-1];
    e_data_reg <= emin_comb;
  end

  // ------------------------------------------------------------ output FIFO
  logic [EW-1:0] fifo_mem [OUT_FIFO_DEPTH];
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0] head;

  always_ff @(posedge clk_in) begin
    if (e_vld_reg) fifo_mem[wr_ptr_reg[PW-1:0]] <= {e_j_reg, e_div0_reg, e_data_reg};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (e_vld_reg) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign out_valid_out = (wr_ptr_reg != rd_ptr_reg);
  assign pop           = out_valid_out & out_ready_in;
  assign head          = fifo_mem[rd_ptr_reg[PW-1:0]];
  // Gate the head so the outputs read 0 while the FIFO is empty.
  assign j_out         = out_valid_out ? head[EW-1 -: AW] : '0;
  assign div0_out      = out_valid_out ? head[BW] : 1'b0;
  assign data_out      = out_valid_out ? head[BW-1:0] : '0;

endmodule
